// File: rtl/wbu_pkg.sv
// Shared definitions for the writeback unit: load funct3 codes, buffer depth
// and the packed skid-buffer entry.
package wbu_pkg;

    localparam int WBU_DEPTH = 2;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LD  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;
    localparam logic [2:0] LD_LWU = 3'b110;

    typedef struct packed {
        logic [4:0]  rd;
        logic [0:0]  we;
        logic [63:0] data;
    } wbu_entry_t;

endpackage

// File: rtl/wbu_load_fmt.sv
// Load data formatter: shifts the addressed lane down and applies the
// sign/zero extension selected by funct3. Purely combinational.
module wbu_load_fmt
    import wbu_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [2:0]  ld_off,
    input  logic [63:0] mem_rdata,
    output logic [63:0] data
);

    logic [63:0] lane_s;

    // Lane select followed by width-dependent extension; ld ignores the offset.
    always_comb begin
        lane_s = mem_rdata >> {ld_off, 3'b000};
        case (ld_op)
            LD_LB:   data = {{56{lane_s[7]}},  lane_s[7:0]};
            LD_LH:   data = {{48{lane_s[15]}}, lane_s[15:0]};
            LD_LW:   data = {{32{lane_s[31]}}, lane_s[31:0]};
            LD_LD:   data = mem_rdata;
            LD_LBU:  data = {56'd0, lane_s[7:0]};
            LD_LHU:  data = {48'd0, lane_s[15:0]};
            LD_LWU:  data = {32'd0, lane_s[31:0]};
            default: data = 64'd0;
        endcase
    end

endmodule

// File: rtl/wbu_stage.sv
// Writeback stage: formats results at accept time, holds them in a 2-entry
// in-order skid buffer and drains the head into the register file write port.
// Optional feature macro: WBU_BYPASS_EN adds a two-port forwarding lookup
// over the buffered entries.
module wbu_stage
    import wbu_pkg::*;
#(
    parameter int DEPTH = WBU_DEPTH,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_wen,
    input  logic            in_is_load,
    input  logic [XLEN-1:0] in_alu_res,
    input  logic [2:0]      in_ld_op,
    input  logic [2:0]      in_ld_off,
    input  logic [XLEN-1:0] in_mem_rdata,
    input  logic            wb_stall,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            retire,
    output logic [XLEN-1:0] instret
`ifdef WBU_BYPASS_EN
    ,
    input  logic [4:0]      byp_raddr1,
    input  logic [4:0]      byp_raddr2,
    output logic            byp_hit1,
    output logic            byp_hit2,
    output logic [XLEN-1:0] byp_data1,
    output logic [XLEN-1:0] byp_data2
`endif
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    // ent0 is always the head (oldest); ent1 is valid only when count is 2.
    wbu_entry_t  ent0_q, ent0_d, ent1_q, ent1_d, new_s;
    logic [1:0]  count_q, count_d;
    logic [63:0] instret_q, instret_d;
    logic [63:0] ld_data_s;
    logic        push_s, pop_s;

    wbu_load_fmt u_load_fmt (
        .ld_op     (in_ld_op),
        .ld_off    (in_ld_off),
        .mem_rdata (in_mem_rdata),
        .data      (ld_data_s)
    );

    // Handshake, entry construction and FIFO next-state.
    always_comb begin
        push_s     = in_valid && (count_q != FULL);
        pop_s      = (count_q != 2'd0) && !wb_stall;
        new_s.rd   = in_rd;
        new_s.we   = 1'(in_wen && (in_rd != 5'd0));
        new_s.data = in_is_load ? ld_data_s : in_alu_res;
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        count_d    = count_q;
        instret_d  = pop_s ? (instret_q + 64'd1) : instret_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (count_q == 2'd0) begin
                    ent0_d = new_s;
                end else begin
                    ent1_d = new_s;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent0_d  = ent1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; new entry lands behind the current tail.
                if (count_q == 2'd1) begin
                    ent0_d = new_s;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = new_s;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // State registers; reset discards buffered entries without writing them.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q    <= '0;
            ent1_q    <= '0;
            count_q   <= 2'd0;
            instret_q <= 64'd0;
        end else begin
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            count_q   <= count_d;
            instret_q <= instret_d;
        end
    end

    // Write port is driven from the head; address/data read 0 when empty.
    always_comb begin
        in_ready = (count_q != FULL);
        retire   = pop_s;
        rf_we    = pop_s && (ent0_q.we == 1'b1);
        if (count_q != 2'd0) begin
            rf_waddr = ent0_q.rd;
            rf_wdata = ent0_q.data;
        end else begin
            rf_waddr = 5'd0;
            rf_wdata = 64'd0;
        end
        instret = instret_q;
    end

`ifdef WBU_BYPASS_EN
    // Youngest matching writer wins; result is {hit, data}.
    function automatic logic [64:0] byp_lookup(input logic [4:0] addr,
                                               input logic [1:0] cnt,
                                               input wbu_entry_t e0,
                                               input wbu_entry_t e1);
        logic [64:0] res;
        res = 65'd0;
        if (addr != 5'd0) begin
            if ((cnt == 2'd2) && (e1.we == 1'b1) && (e1.rd == addr)) begin
                res = {1'b1, e1.data};
            end else if ((cnt != 2'd0) && (e0.we == 1'b1) && (e0.rd == addr)) begin
                res = {1'b1, e0.data};
            end else begin
                res = 65'd0;
            end
        end else begin
            res = 65'd0;
        end
        return res;
    endfunction

    // Forwarding lookup for both read ports, independent of the stall.
    always_comb begin
        {byp_hit1, byp_data1} = byp_lookup(byp_raddr1, count_q, ent0_q, ent1_q);
        {byp_hit2, byp_data2} = byp_lookup(byp_raddr2, count_q, ent0_q, ent1_q);
    end
`endif

endmodule

// File: tb/tb_wbu_stage.sv
// Scoreboard bench for wbu_stage: the driver pushes the hand-computed write
// expected for each accepted instruction; a negedge monitor pops and compares
// on every retire.
module tb_wbu_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = 5'd0;
    logic        in_wen = 1'b0;
    logic        in_is_load = 1'b0;
    logic [63:0] in_alu_res = 64'd0;
    logic [2:0]  in_ld_op = 3'd0;
    logic [2:0]  in_ld_off = 3'd0;
    logic [63:0] in_mem_rdata = 64'd0;
    logic        wb_stall = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        retire;
    logic [63:0] instret;
`ifdef WBU_BYPASS_EN
    logic [4:0]  byp_raddr1 = 5'd0;
    logic [4:0]  byp_raddr2 = 5'd0;
    logic        byp_hit1, byp_hit2;
    logic [63:0] byp_data1, byp_data2;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int retired_n = 0;
    logic [69:0] exp_q[$];   // {we, waddr, wdata}

    wbu_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_wen(in_wen), .in_is_load(in_is_load),
        .in_alu_res(in_alu_res), .in_ld_op(in_ld_op), .in_ld_off(in_ld_off),
        .in_mem_rdata(in_mem_rdata), .wb_stall(wb_stall), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire(retire),
        .instret(instret)
`ifdef WBU_BYPASS_EN
        , .byp_raddr1(byp_raddr1), .byp_raddr2(byp_raddr2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Offer one instruction until accepted; pushes expectation before the accepting edge.
    task automatic send(input logic [4:0] rd, input logic wen, input logic ld,
                        input logic [63:0] alu, input logic [2:0] op,
                        input logic [2:0] off, input logic [63:0] md,
                        input logic exp_we, input logic [63:0] exp_data,
                        output int waited);
        logic acc;
        in_valid = 1'b1; in_rd = rd; in_wen = wen; in_is_load = ld;
        in_alu_res = alu; in_ld_op = op; in_ld_off = off; in_mem_rdata = md;
        acc = 1'b0;
        waited = 0;
        while (!acc && waited < 50) begin
            acc = in_ready;
            if (acc) exp_q.push_back({exp_we, rd, exp_data});
            @(posedge clk); #1;
            if (!acc) waited++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: rd %0d never accepted", rd);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 50) begin
            @(posedge clk); #1; c++;
        end
        @(posedge clk); #1;
        chk("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every retire must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && retire) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_retire: waddr %0d data %h", rf_waddr, rf_wdata);
            end else begin
                logic [69:0] e;
                e = exp_q.pop_front();
                chk("rf_we", 64'(rf_we), 64'(e[69]));
                chk("rf_waddr", 64'(rf_waddr), 64'(e[68:64]));
                chk("rf_wdata", rf_wdata, e[63:0]);
            end
            retired_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] MD = 64'h8899AABB_11223344;

    initial begin
        int w, w2;
        logic [63:0] base;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_instret", instret, 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_retire", 64'(retire), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", rf_wdata, 64'd0);
        rst = 1'b0;

        // Load formatting vectors.
        send(5'd1, 1'b1, 1'b1, 64'd0, 3'b000, 3'd4, MD, 1'b1, 64'hFFFF_FFFF_FFFF_FFBB, w);
        send(5'd2, 1'b1, 1'b1, 64'd0, 3'b100, 3'd4, MD, 1'b1, 64'h0000_0000_0000_00BB, w);
        send(5'd3, 1'b1, 1'b1, 64'd0, 3'b010, 3'd4, MD, 1'b1, 64'hFFFF_FFFF_8899_AABB, w);
        send(5'd4, 1'b1, 1'b1, 64'd0, 3'b110, 3'd4, MD, 1'b1, 64'h0000_0000_8899_AABB, w);
        send(5'd5, 1'b1, 1'b1, 64'd0, 3'b011, 3'd0, MD, 1'b1, MD, w);
        send(5'd6, 1'b1, 1'b1, 64'd0, 3'b011, 3'd4, MD, 1'b1, MD, w);
        send(5'd7, 1'b1, 1'b1, 64'd0, 3'b001, 3'd4, MD, 1'b1, 64'hFFFF_FFFF_FFFF_AABB, w);
        send(5'd8, 1'b1, 1'b1, 64'd0, 3'b101, 3'd4, MD, 1'b1, 64'h0000_0000_0000_AABB, w);
        send(5'd9, 1'b1, 1'b1, 64'd0, 3'b000, 3'd0, MD, 1'b1, 64'h0000_0000_0000_0044, w);
        send(5'd10, 1'b1, 1'b1, 64'd0, 3'b000, 3'd7, MD, 1'b1, 64'hFFFF_FFFF_FFFF_FF88, w);
        send(5'd11, 1'b1, 1'b1, 64'd0, 3'b111, 3'd4, MD, 1'b1, 64'd0, w);
        send(5'd12, 1'b1, 1'b0, 64'h1234, 3'b000, 3'd4, MD, 1'b1, 64'h1234, w);
        drain();
        chk("instret_after_loads", instret, 64'(retired_n));

        // Back-to-back ALU writes, unstalled.
        base = instret;
        send(5'd5, 1'b1, 1'b0, 64'h1, 3'd0, 3'd0, 64'd0, 1'b1, 64'h1, w);
        chk("b2b_wait0", 64'(w), 64'd0);
        chk("b2b_we0", 64'(rf_we), 64'd1);
        chk("b2b_addr0", 64'(rf_waddr), 64'd5);
        send(5'd6, 1'b1, 1'b0, 64'h2, 3'd0, 3'd0, 64'd0, 1'b1, 64'h2, w);
        chk("b2b_wait1", 64'(w), 64'd0);
        chk("b2b_we1", 64'(rf_we), 64'd1);
        chk("b2b_addr1", 64'(rf_waddr), 64'd6);
        chk("b2b_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("b2b_instret", instret - base, 64'd2);

        // Write to x0 retires without a register write.
        base = instret;
        send(5'd0, 1'b1, 1'b0, 64'h55, 3'd0, 3'd0, 64'd0, 1'b0, 64'h55, w);
        chk("x0_retire", 64'(retire), 64'd1);
        chk("x0_we", 64'(rf_we), 64'd0);
        @(posedge clk); #1;
        chk("x0_instret", instret - base, 64'd1);

        // Stall with three offers; third goes in only after draining starts.
        wb_stall = 1'b1;
        send(5'd20, 1'b1, 1'b0, 64'hA0, 3'd0, 3'd0, 64'd0, 1'b1, 64'hA0, w);
        send(5'd21, 1'b0, 1'b0, 64'hA1, 3'd0, 3'd0, 64'd0, 1'b0, 64'hA1, w);
        chk("stall_ready0", 64'(in_ready), 64'd0);
        chk("stall_retire", 64'(retire), 64'd0);
        chk("stall_we", 64'(rf_we), 64'd0);
        chk("stall_head", 64'(rf_waddr), 64'd20);
`ifdef WBU_BYPASS_EN
        byp_raddr1 = 5'd20; byp_raddr2 = 5'd21;
        #1;
        chk("byp_hit_a", 64'(byp_hit1), 64'd1);
        chk("byp_data_a", byp_data1, 64'hA0);
        chk("byp_nowen", 64'(byp_hit2), 64'd0);
`endif
        fork
            send(5'd22, 1'b1, 1'b0, 64'hA2, 3'd0, 3'd0, 64'd0, 1'b1, 64'hA2, w2);
            begin
                @(posedge clk); @(posedge clk); #2;
                wb_stall = 1'b0;
            end
        join
        chk("stall_third_wait", 64'(w2), 64'd3);
        drain();
        chk("instret_after_stall", instret, 64'(retired_n));

`ifdef WBU_BYPASS_EN
        // Youngest of two same-rd writers supplies the forwarded value.
        wb_stall = 1'b1;
        send(5'd7, 1'b1, 1'b0, 64'hA, 3'd0, 3'd0, 64'd0, 1'b1, 64'hA, w);
        send(5'd7, 1'b1, 1'b0, 64'hB, 3'd0, 3'd0, 64'd0, 1'b1, 64'hB, w);
        byp_raddr1 = 5'd7; byp_raddr2 = 5'd0;
        #1;
        chk("byp_hit1", 64'(byp_hit1), 64'd1);
        chk("byp_data1", byp_data1, 64'hB);
        chk("byp_hit2_x0", 64'(byp_hit2), 64'd0);
        chk("byp_data2_x0", byp_data2, 64'd0);
        wb_stall = 1'b0;
        drain();
`endif

        // Reset with two buffered entries discards them.
        wb_stall = 1'b1;
        send(5'd13, 1'b1, 1'b0, 64'hDEAD, 3'd0, 3'd0, 64'd0, 1'b1, 64'hDEAD, w);
        send(5'd14, 1'b1, 1'b0, 64'hBEEF, 3'd0, 3'd0, 64'd0, 1'b1, 64'hBEEF, w);
        chk("pre_rst_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        retired_n = 0;
        wb_stall = 1'b0;
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_instret", instret, 64'd0);
        chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_retire", 64'(retire), 64'd0);
        chk("mid_rst_wdata", rf_wdata, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_instret", instret, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wbu_stage.md
# wbu_stage

Writeback unit between the execute/load path and the 32×64-bit register file write port of the NPC core. Accepts one completed instruction per cycle over a valid/ready handshake, formats load data (byte select plus sign/zero extension), and holds results in a 2-entry skid buffer. Drains the buffer into the register file write port, suppresses writes to x0, and counts retired instructions.

## Interface
- `DEPTH`, 2: skid buffer entries. Fixed at 2; no other value is supported.
- `XLEN`, 64: datapath width.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream holds a completed instruction.
- `in_ready` out 1: buffer can accept. Driven from registered state only.
- `in_rd` in 5: destination register.
- `in_wen` in 1: instruction writes `rd`.
- `in_is_load` in 1: 1 selects load data, 0 selects `in_alu_res`.
- `in_alu_res` in 64: ALU/CSR result.
- `in_ld_op` in 3: funct3. 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
- `in_ld_off` in 3: byte offset of the access within the 64-bit word.
- `in_mem_rdata` in 64: aligned doubleword from the LSU.
- `wb_stall` in 1: blocks draining (debug halt or shared-port arbitration).
- `rf_we` out 1, `rf_waddr` out 5, `rf_wdata` out 64: register file write port.
- `retire` out 1: pulses for each entry leaving the buffer.
- `instret` out 64: count of retired entries.
- Present only with `WBU_BYPASS_EN`:
  - `byp_raddr1`, `byp_raddr2` in 5 each.
  - `byp_hit1`, `byp_hit2` out 1 each.
  - `byp_data1`, `byp_data2` out 64 each.

## Operation
- Accept occurs when `in_valid && in_ready`. The final 64-bit value is computed at accept time and stored in the entry together with `rd` and `we_eff = in_wen && (in_rd != 0)`.
- Load formatting:
  - Select the lane `in_mem_rdata >> (8*in_ld_off)`.
  - lb/lh/lw sign-extend the low 8/16/32 bits.
  - lbu/lhu/lwu zero-extend.
  - ld passes the doubleword unchanged and ignores `in_ld_off`.
  - funct3 111 produces 0.
  - Misaligned offsets are not checked; low bits are taken as shifted.
- Buffer is a FIFO with occupancy `count` in {0,1,2}. The head is the oldest entry.
- `in_ready = (count != 2)`.
- Drain occurs when `count != 0 && !wb_stall`:
  - `retire = 1`.
  - `rf_we = head.we_eff`, with `rf_waddr`/`rf_wdata` taken from the head.
  - The head is popped at the edge.
- While not draining, `rf_we = 0` and `retire = 0`. `rf_waddr`/`rf_wdata` hold the head value, or 0 when empty.
- Accept and drain in the same cycle leave `count` unchanged and keep order: the new entry goes behind the current tail.
- Entries with `we_eff = 0` still retire and increment `instret`. They never assert `rf_we`.
- `instret` wraps modulo 2^64.
- Reset values: `count = 0`, `instret = 0`, `in_ready = 1`, `rf_we = 0`, `rf_waddr = 0`, `rf_wdata = 0`, `retire = 0`.
- Reset asserted mid-operation discards all buffered entries without writing them.

## Timing
- An instruction accepted at edge N appears as head during cycle N→N+1, with `rf_we` high if unstalled. The register file captures it at edge N+1, so latency is 1 cycle.
- Throughput is 1 instruction/cycle with `wb_stall = 0`.
- `wb_stall` held for k cycles delays the head k cycles. After 2 accepts during a stall, `in_ready` falls in the following cycle.
- `in_ready` never depends combinationally on `in_valid` or `wb_stall`.

## Configuration
- `WBU_BYPASS_EN` defined:
  - Compare each `byp_raddrX` against all valid entries with `we_eff`.
  - Hit on a match with a nonzero address; the youngest matching entry supplies `byp_dataX`.
  - Combinational, and independent of `wb_stall`.
  - No hit gives `byp_hitX = 0` and `byp_dataX = 0`.
- `WBU_BYPASS_EN` undefined: the bypass ports and logic are absent. The decoder must stall on pending writes instead.

## Structure
- Shared package `wbu_pkg`:
  - funct3 load-op constants (`LD_LB` … `LD_LWU`).
  - `WBU_DEPTH = 2`.
  - Packed entry struct {`rd` [4:0], `we` [0:0], `data` [63:0]}.
- Sub-module `wbu_load_fmt`: purely combinational `(ld_op, ld_off, mem_rdata) -> data`.
- Buffer, handshake and counter live in `wbu_stage`.

## Test plan
- Loads, offset 4, `in_mem_rdata = 64'h8899AABB_11223344`:
  - lb → `64'hFFFF_FFFF_FFFF_FFBB`.
  - lbu → `64'hBB`.
  - lw → `64'hFFFF_FFFF_8899_AABB`.
  - lwu → `64'h8899_AABB`.
  - Same data, offset 0, ld → unchanged.
- Back-to-back ALU writes rd=5 `64'h1`, rd=6 `64'h2`, no stall → `rf_we` high two consecutive cycles, writing x5 then x6, `instret = 2`, `in_ready` stays 1.
- Write to rd=0 with `in_wen = 1` → `rf_we = 0`, `retire = 1`, `instret` increments by 1.
- `wb_stall = 1`, three valid offers → first two accepted, `in_ready = 0` from the cycle after the second accept. Release stall → entries drain in order, then the third is accepted.
- Two buffered entries, assert `rst` one cycle → no `rf_we`, `count = 0`, `instret = 0`, `in_ready = 1` next cycle.
- `WBU_BYPASS_EN`: two stalled entries, both rd=7 (`64'hA` older, `64'hB` younger), `byp_raddr1 = 7` → `byp_hit1 = 1`, `byp_data1 = 64'hB`. `byp_raddr2 = 0` → `byp_hit2 = 0`.
